// File: rtl/ddr3_ram_arbiter.sv
// Two-port round-robin arbiter in front of the ddr3_core RAM port.
// Requests are tagged with their source port in req_id[15]; responses are routed back by that tag.
module ddr3_ram_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,

    input  logic [15:0]  inport0_wr_i,
    input  logic         inport0_rd_i,
    input  logic [31:0]  inport0_addr_i,
    input  logic [127:0] inport0_write_data_i,
    input  logic [14:0]  inport0_req_id_i,
    output logic         inport0_accept_o,
    output logic         inport0_ack_o,
    output logic         inport0_error_o,
    output logic [127:0] inport0_read_data_o,
    output logic [14:0]  inport0_resp_id_o,

    input  logic [15:0]  inport1_wr_i,
    input  logic         inport1_rd_i,
    input  logic [31:0]  inport1_addr_i,
    input  logic [127:0] inport1_write_data_i,
    input  logic [14:0]  inport1_req_id_i,
    output logic         inport1_accept_o,
    output logic         inport1_ack_o,
    output logic         inport1_error_o,
    output logic [127:0] inport1_read_data_o,
    output logic [14:0]  inport1_resp_id_o,

    output logic [15:0]  outport_wr_o,
    output logic         outport_rd_o,
    output logic [31:0]  outport_addr_o,
    output logic [127:0] outport_write_data_o,
    output logic [15:0]  outport_req_id_o,
    input  logic         outport_accept_i,
    input  logic         outport_ack_i,
    input  logic         outport_error_i,
    input  logic [127:0] outport_read_data_i,
    input  logic [15:0]  outport_resp_id_i
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] outstanding0;
    logic [CNT_W-1:0] outstanding1;
    logic             last_grant;

    logic pending0, pending1;
    logic eligible0, eligible1;
    logic grant_valid, grant_port;
    logic inc0, inc1, dec0, dec1;

    assign pending0  = (inport0_wr_i != 16'd0) | inport0_rd_i;
    assign pending1  = (inport1_wr_i != 16'd0) | inport1_rd_i;
    assign eligible0 = pending0 & (outstanding0 < CNT_MAX);
    assign eligible1 = pending1 & (outstanding1 < CNT_MAX);

    // On a tie the port that did not win the last accepted handshake goes next.
    always_comb begin
        grant_valid = eligible0 | eligible1;
        grant_port  = 1'b0;
        if (eligible0 && eligible1) begin
            grant_port = ~last_grant;
        end else if (eligible1) begin
            grant_port = 1'b1;
        end
    end

    always_comb begin
        outport_wr_o         = 16'd0;
        outport_rd_o         = 1'b0;
        outport_addr_o       = 32'd0;
        outport_write_data_o = 128'd0;
        outport_req_id_o     = 16'd0;
        if (grant_valid) begin
            if (grant_port) begin
                outport_wr_o         = inport1_wr_i;
                outport_rd_o         = inport1_rd_i;
                outport_addr_o       = inport1_addr_i;
                outport_write_data_o = inport1_write_data_i;
                outport_req_id_o     = {1'b1, inport1_req_id_i};
            end else begin
                outport_wr_o         = inport0_wr_i;
                outport_rd_o         = inport0_rd_i;
                outport_addr_o       = inport0_addr_i;
                outport_write_data_o = inport0_write_data_i;
                outport_req_id_o     = {1'b0, inport0_req_id_i};
            end
        end
    end

    assign inport0_accept_o = outport_accept_i & grant_valid & ~grant_port;
    assign inport1_accept_o = outport_accept_i & grant_valid & grant_port;

    always_comb begin
        inport0_ack_o       = 1'b0;
        inport0_error_o     = 1'b0;
        inport0_read_data_o = 128'd0;
        inport0_resp_id_o   = 15'd0;
        inport1_ack_o       = 1'b0;
        inport1_error_o     = 1'b0;
        inport1_read_data_o = 128'd0;
        inport1_resp_id_o   = 15'd0;
        if (outport_resp_id_i[15]) begin
            inport1_ack_o       = outport_ack_i;
            inport1_error_o     = outport_error_i;
            inport1_read_data_o = outport_read_data_i;
            inport1_resp_id_o   = outport_resp_id_i[14:0];
        end else begin
            inport0_ack_o       = outport_ack_i;
            inport0_error_o     = outport_error_i;
            inport0_read_data_o = outport_read_data_i;
            inport0_resp_id_o   = outport_resp_id_i[14:0];
        end
    end

    assign inc0 = inport0_accept_o;
    assign inc1 = inport1_accept_o;
    assign dec0 = outport_ack_i & ~outport_resp_id_i[15];
    assign dec1 = outport_ack_i & outport_resp_id_i[15];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= 1'b1;
        end else if (outport_accept_i && grant_valid) begin
            last_grant <= grant_port;
        end
    end

    // A stray ack at zero is ignored rather than wrapping the counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding0 <= '0;
            outstanding1 <= '0;
        end else begin
            if (inc0 && !dec0) begin
                outstanding0 <= outstanding0 + CNT_W'(1);
            end else if (!inc0 && dec0 && (outstanding0 != '0)) begin
                outstanding0 <= outstanding0 - CNT_W'(1);
            end
            if (inc1 && !dec1) begin
                outstanding1 <= outstanding1 + CNT_W'(1);
            end else if (!inc1 && dec1 && (outstanding1 != '0)) begin
                outstanding1 <= outstanding1 - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ddr3_ram_arbiter.sv
// Scoreboard bench for ddr3_ram_arbiter: the driver queues expected core requests and
// port responses, a negedge monitor pops and compares them whenever a handshake or ack shows up.
module tb_ddr3_ram_arbiter;

    typedef struct packed {
        logic [15:0]  wr;
        logic         rd;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [15:0]  id;
    } req_t;

    typedef struct packed {
        logic         err;
        logic [127:0] data;
        logic [14:0]  id;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  p0_wr, p1_wr;
    logic         p0_rd, p1_rd;
    logic [31:0]  p0_addr, p1_addr;
    logic [127:0] p0_data, p1_data;
    logic [14:0]  p0_id, p1_id;
    logic         o0_accept, o0_ack, o0_error, o1_accept, o1_ack, o1_error;
    logic [127:0] o0_rdata, o1_rdata;
    logic [14:0]  o0_rid, o1_rid;
    logic [15:0]  out_wr;
    logic         out_rd;
    logic [31:0]  out_addr;
    logic [127:0] out_wdata;
    logic [15:0]  out_id;
    logic         acc, ack, err;
    logic [127:0] rdata;
    logic [15:0]  rid;

    int   checks = 0;
    int   errors = 0;
    req_t exp_req[$];
    rsp_t exp_rsp0[$];
    rsp_t exp_rsp1[$];
    req_t got_r, want_r;
    rsp_t got_s, want_s;

    always #5 clk = ~clk;

    ddr3_ram_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .inport0_wr_i(p0_wr), .inport0_rd_i(p0_rd), .inport0_addr_i(p0_addr),
        .inport0_write_data_i(p0_data), .inport0_req_id_i(p0_id),
        .inport0_accept_o(o0_accept), .inport0_ack_o(o0_ack), .inport0_error_o(o0_error),
        .inport0_read_data_o(o0_rdata), .inport0_resp_id_o(o0_rid),
        .inport1_wr_i(p1_wr), .inport1_rd_i(p1_rd), .inport1_addr_i(p1_addr),
        .inport1_write_data_i(p1_data), .inport1_req_id_i(p1_id),
        .inport1_accept_o(o1_accept), .inport1_ack_o(o1_ack), .inport1_error_o(o1_error),
        .inport1_read_data_o(o1_rdata), .inport1_resp_id_o(o1_rid),
        .outport_wr_o(out_wr), .outport_rd_o(out_rd), .outport_addr_o(out_addr),
        .outport_write_data_o(out_wdata), .outport_req_id_o(out_id),
        .outport_accept_i(acc), .outport_ack_i(ack), .outport_error_i(err),
        .outport_read_data_i(rdata), .outport_resp_id_i(rid)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [15:0] wr, input logic rd, input logic [31:0] addr,
                        input logic [127:0] data, input logic [14:0] id);
        p0_wr = wr; p0_rd = rd; p0_addr = addr; p0_data = data; p0_id = id;
    endtask

    task automatic set1(input logic [15:0] wr, input logic rd, input logic [31:0] addr,
                        input logic [127:0] data, input logic [14:0] id);
        p1_wr = wr; p1_rd = rd; p1_addr = addr; p1_data = data; p1_id = id;
    endtask

    task automatic push_req(input logic [15:0] wr, input logic rd, input logic [31:0] addr,
                            input logic [127:0] data, input logic [15:0] id);
        req_t r;
        r = {wr, rd, addr, data, id};
        exp_req.push_back(r);
    endtask

    task automatic drive_ack(input logic [15:0] id, input logic e, input logic [127:0] d);
        rsp_t s;
        ack = 1'b1; rid = id; err = e; rdata = d;
        s = {e, d, id[14:0]};
        if (id[15]) exp_rsp1.push_back(s);
        else        exp_rsp0.push_back(s);
    endtask

    task automatic ack_off();
        ack = 1'b0; rid = '0; err = 1'b0; rdata = '0;
    endtask

    // Monitor: every core handshake and every port ack must match the next queued expectation.
    always @(negedge clk) begin
        if (acc && (out_rd || out_wr != '0)) begin
            got_r = {out_wr, out_rd, out_addr, out_wdata, out_id};
            checks++;
            if (exp_req.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected: got %0h expected none", got_r);
            end else begin
                want_r = exp_req.pop_front();
                if (got_r !== want_r) begin
                    errors++;
                    $display("FAIL req: got %0h expected %0h", got_r, want_r);
                end
            end
        end
        if (o0_ack) begin
            got_s = {o0_error, o0_rdata, o0_rid};
            checks++;
            if (exp_rsp0.size() == 0) begin
                errors++;
                $display("FAIL rsp0_unexpected: got %0h expected none", got_s);
            end else begin
                want_s = exp_rsp0.pop_front();
                if (got_s !== want_s) begin
                    errors++;
                    $display("FAIL rsp0: got %0h expected %0h", got_s, want_s);
                end
            end
        end
        if (o1_ack) begin
            got_s = {o1_error, o1_rdata, o1_rid};
            checks++;
            if (exp_rsp1.size() == 0) begin
                errors++;
                $display("FAIL rsp1_unexpected: got %0h expected none", got_s);
            end else begin
                want_s = exp_rsp1.pop_front();
                if (got_s !== want_s) begin
                    errors++;
                    $display("FAIL rsp1: got %0h expected %0h", got_s, want_s);
                end
            end
        end
    end

    logic [15:0] ack_ids [4];

    initial begin
        rst = 1'b1;
        set0('0, 1'b0, '0, '0, '0);
        set1('0, 1'b0, '0, '0, '0);
        acc = 1'b0;
        ack_off();
        repeat (2) nxt();
        @(negedge clk);
        chk("rst_out_rd", 128'(out_rd), 128'(1'b0));
        chk("rst_out_id", 128'(out_id), 128'(16'h0));
        chk("rst_ack0", 128'(o0_ack), 128'(1'b0));
        chk("rst_acc1", 128'(o1_accept), 128'(1'b0));
        rst = 1'b0;

        // Single read on port0, then a port1 write with a port0 ack in the same cycle.
        nxt();
        set0('0, 1'b1, 32'h100, '0, 15'd5);
        acc = 1'b1;
        push_req('0, 1'b1, 32'h100, '0, 16'h0005);
        @(negedge clk);
        chk("t1_rd", 128'(out_rd), 128'(1'b1));
        chk("t1_req_id", 128'(out_id), 128'(16'h0005));
        chk("t1_acc0", 128'(o0_accept), 128'(1'b1));
        chk("t1_acc1", 128'(o1_accept), 128'(1'b0));
        nxt();
        set0('0, 1'b0, '0, '0, '0);
        set1(16'h00F0, 1'b0, 32'h200, {4{32'hDEADBEEF}}, 15'd7);
        push_req(16'h00F0, 1'b0, 32'h200, {4{32'hDEADBEEF}}, 16'h8007);
        drive_ack(16'h0005, 1'b0, {4{32'h12345678}});
        @(negedge clk);
        chk("t1_wr_acc1", 128'(o1_accept), 128'(1'b1));
        chk("t1_ack1_idle", 128'(o1_ack), 128'(1'b0));
        chk("t1_data1_idle", o1_rdata, 128'h0);
        nxt();
        set1('0, 1'b0, '0, '0, '0);
        drive_ack(16'h8007, 1'b1, '0);
        @(negedge clk);
        chk("t1_err1", 128'(o1_error), 128'(1'b1));
        nxt();
        ack_off();

        // Both ports request every cycle: grants alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            set0('0, 1'b1, 32'h1000 + 32'(k), '0, 15'h10 + 15'(k));
            set1('0, 1'b1, 32'h2000 + 32'(k), '0, 15'h20 + 15'(k));
            if (k % 2 == 0) push_req('0, 1'b1, 32'h1000 + 32'(k), '0, 16'h0010 + 16'(k));
            else            push_req('0, 1'b1, 32'h2000 + 32'(k), '0, 16'h8020 + 16'(k));
            @(negedge clk);
            chk("t2_grant0", 128'(o0_accept), 128'(k % 2 == 0));
            nxt();
        end
        set0('0, 1'b0, '0, '0, '0);
        set1('0, 1'b0, '0, '0, '0);
        ack_ids = '{16'h0010, 16'h8021, 16'h0012, 16'h8023};
        for (int k = 0; k < 4; k++) begin
            drive_ack(ack_ids[k], 1'b0, {4{32'hA0000000 + 32'(k)}});
            nxt();
        end
        ack_off();

        // Port1 fills its four slots; the fifth is held until an ack frees one.
        for (int k = 0; k < 4; k++) begin
            set1('0, 1'b1, 32'h3000 + 32'(k), '0, 15'(k));
            push_req('0, 1'b1, 32'h3000 + 32'(k), '0, 16'h8000 + 16'(k));
            nxt();
        end
        set1('0, 1'b1, 32'h3004, '0, 15'd4);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t3_held_rd", 128'(out_rd), 128'(1'b0));
            chk("t3_held_acc1", 128'(o1_accept), 128'(1'b0));
            nxt();
        end
        drive_ack(16'h8003, 1'b0, {4{32'hB0B0B0B0}});
        @(negedge clk);
        chk("t3_ack_cycle_rd", 128'(out_rd), 128'(1'b0));
        chk("t3_ack1", 128'(o1_ack), 128'(1'b1));
        chk("t3_rid1", 128'(o1_rid), 128'(15'd3));
        chk("t3_ack0_quiet", 128'(o0_ack), 128'(1'b0));
        nxt();
        ack_off();
        push_req('0, 1'b1, 32'h3004, '0, 16'h8004);
        @(negedge clk);
        chk("t3_fifth_rd", 128'(out_rd), 128'(1'b1));
        chk("t3_fifth_acc1", 128'(o1_accept), 128'(1'b1));
        nxt();
        set1('0, 1'b0, '0, '0, '0);
        ack_ids = '{16'h8000, 16'h8001, 16'h8002, 16'h8004};
        for (int k = 0; k < 4; k++) begin
            drive_ack(ack_ids[k], 1'b0, {4{32'hC0000000 + 32'(k)}});
            nxt();
        end
        ack_off();

        // Accept and ack of port0 in the same cycle leave its count unchanged.
        for (int k = 0; k < 3; k++) begin
            set0('0, 1'b1, 32'h4000 + 32'(k), '0, 15'h40 + 15'(k));
            push_req('0, 1'b1, 32'h4000 + 32'(k), '0, 16'h0040 + 16'(k));
            nxt();
        end
        set0('0, 1'b1, 32'h4003, '0, 15'h43);
        push_req('0, 1'b1, 32'h4003, '0, 16'h0043);
        drive_ack(16'h0040, 1'b0, {4{32'hD0D0D0D0}});
        @(negedge clk);
        chk("t4_same_cycle_acc0", 128'(o0_accept), 128'(1'b1));
        nxt();
        ack_off();
        set0('0, 1'b1, 32'h4004, '0, 15'h44);
        push_req('0, 1'b1, 32'h4004, '0, 16'h0044);
        @(negedge clk);
        chk("t4_fourth_acc0", 128'(o0_accept), 128'(1'b1));
        nxt();
        set0('0, 1'b1, 32'h4005, '0, 15'h45);
        @(negedge clk);
        chk("t4_full_rd", 128'(out_rd), 128'(1'b0));
        chk("t4_full_acc0", 128'(o0_accept), 128'(1'b0));
        nxt();
        set0('0, 1'b0, '0, '0, '0);
        for (int k = 1; k < 5; k++) begin
            drive_ack(16'h0040 + 16'(k), 1'b0, {4{32'hE0000000 + 32'(k)}});
            nxt();
        end
        ack_off();

        // Core stalls with both pending: grant stays on port1 (port0 won last).
        acc = 1'b0;
        set0('0, 1'b1, 32'h5000, '0, 15'h50);
        set1('0, 1'b1, 32'h5100, '0, 15'h51);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_stall_id", 128'(out_id), 128'(16'h8051));
            chk("t5_stall_addr", 128'(out_addr), 128'(32'h5100));
            chk("t5_stall_acc1", 128'(o1_accept), 128'(1'b0));
            nxt();
        end
        acc = 1'b1;
        push_req('0, 1'b1, 32'h5100, '0, 16'h8051);
        nxt();
        set1('0, 1'b1, 32'h5200, '0, 15'h52);
        push_req('0, 1'b1, 32'h5000, '0, 16'h0050);
        nxt();
        set0('0, 1'b1, 32'h5300, '0, 15'h53);
        push_req('0, 1'b1, 32'h5200, '0, 16'h8052);
        nxt();
        set1('0, 1'b1, 32'h5400, '0, 15'h54);
        push_req('0, 1'b1, 32'h5300, '0, 16'h0053);
        nxt();

        // Reset mid-burst with two outstanding per port.
        acc = 1'b0;
        rst = 1'b1;
        set0('0, 1'b1, 32'h5500, '0, 15'h55);
        @(negedge clk);
        chk("t6_rst_tie_id", 128'(out_id), 128'(16'h0055));
        nxt();
        rst = 1'b0;
        acc = 1'b1;
        push_req('0, 1'b1, 32'h5500, '0, 16'h0055);
        @(negedge clk);
        chk("t6_tie_acc0", 128'(o0_accept), 128'(1'b1));
        nxt();
        set0('0, 1'b1, 32'h5600, '0, 15'h56);
        push_req('0, 1'b1, 32'h5400, '0, 16'h8054);
        nxt();
        set1('0, 1'b0, '0, '0, '0);
        for (int k = 6; k < 9; k++) begin
            set0('0, 1'b1, 32'h5000 + 32'(k) * 32'h100, '0, 15'h50 + 15'(k));
            push_req('0, 1'b1, 32'h5000 + 32'(k) * 32'h100, '0, 16'h0050 + 16'(k));
            @(negedge clk);
            chk("t6_refill_acc0", 128'(o0_accept), 128'(1'b1));
            nxt();
        end
        set0('0, 1'b1, 32'h5900, '0, 15'h59);
        @(negedge clk);
        chk("t6_full_rd", 128'(out_rd), 128'(1'b0));
        nxt();
        set0('0, 1'b0, '0, '0, '0);
        acc = 1'b0;
        nxt();
        @(negedge clk);

        chk("end_req_queue", 128'(exp_req.size()), 128'(0));
        chk("end_rsp0_queue", 128'(exp_rsp0.size()), 128'(0));
        chk("end_rsp1_queue", 128'(exp_rsp1.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
